dac_i2s_tx: RTL and testbench

I2S transmitter for the WM8731 DAC path, the playback counterpart of the mic capture path. It buffers a 16-bit mono sample stream in a small FIFO and serialises each sample MSB-first onto AUD_DACDAT, sending the same sample in both the left and right half-frames. The codec is clock master and drives AUD_BCLK and AUD_DACLRCK. Intended first use is 48 kHz mic loopback monitoring, fed from the mic valid/sample stream on the same AUD_BCLK domain.

---
 rtl/dac_i2s_tx.sv | 70 +++++++
 tb/tb_dac_i2s_tx.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/dac_i2s_tx.sv
// dac_i2s_tx: I2S DAC transmitter; FIFO-buffered mono samples, sent MSB-first in both half-frames
module dac_i2s_tx #(
   parameter int N     = 16,
   parameter int DEPTH = 4
) (
   input  logic                   AUD_BCLK,
   input  logic                   rst_n,
   input  logic                   AUD_DACLRCK,
   input  logic                   s_valid,
   output logic                   s_ready,
   input  logic [N-1:0]           s_data,
   output logic                   AUD_DACDAT,
   output logic [$clog2(DEPTH):0] fifo_level,
   output logic                   underflow
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int CW = $clog2(N);
   logic [N-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic          lrck_q;
   logic [N-1:0]  cur, shreg, w;
   logic [CW-1:0] bitcnt;
   logic          lr_edge, fall, push, pop;
   always_comb begin
      lr_edge = AUD_DACLRCK != lrck_q;
      fall    = lr_edge && !AUD_DACLRCK;
      s_ready = fifo_level < LW'(DEPTH);
      push    = s_valid && s_ready;
      pop     = fall && fifo_level != '0;
      w       = pop ? mem[rd_ptr] : cur;
   end
   always_ff @(posedge AUD_BCLK)
      if (push) mem[wr_ptr] <= s_data;
   // lrck_q tracks the pin through reset so release never fakes an edge
   always_ff @(posedge AUD_BCLK)
      lrck_q <= AUD_DACLRCK;
   always_ff @(posedge AUD_BCLK) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
         cur        <= '0;
         shreg      <= '0;
         bitcnt     <= '0;
         AUD_DACDAT <= 1'b0;
         underflow  <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
            cur    <= mem[rd_ptr];
         end
         fifo_level <= fifo_level + LW'(push) - LW'(pop);
         underflow  <= fall && fifo_level == '0;
         // any edge restarts the word, truncating one still in flight
         if (lr_edge) begin
            AUD_DACDAT <= w[N-1];
            shreg      <= {w[N-2:0], 1'b0};
            bitcnt     <= CW'(N - 1);
         end else if (bitcnt != '0) begin
            AUD_DACDAT <= shreg[N-1];
            shreg      <= {shreg[N-2:0], 1'b0};
            bitcnt     <= bitcnt - 1'b1;
         end else begin
            AUD_DACDAT <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_dac_i2s_tx.sv
// tb_dac_i2s_tx: directed and random stimulus for dac_i2s_tx against a queue-based reference model
module tb_dac_i2s_tx;
   localparam int N = 16;
   localparam int DEPTH = 4;
   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          lrck = 1'b1;
   logic          s_valid = 1'b0;
   logic [N-1:0]  s_data = '0;
   logic          s_ready, dacdat, underflow;
   logic [2:0]    fifo_level;
   int            total = 0, bad = 0;
   logic [N-1:0]  q[$];
   logic [N-1:0]  sent[$];
   logic [N-1:0]  m_cur = '0, m_word = '0, cap = '0, trunc = '0;
   int            m_pos = N;
   logic          m_prev = 1'b1, m_uf = 1'b0;
   int            lcnt = 0, cur_len = 32, uf_cnt = 0, max_level = 0, low_ready = 0;
   logic          short_req = 1'b0;
   logic [N-1:0]  r1, r2, r3;

   dac_i2s_tx #(.N(N), .DEPTH(DEPTH)) dut (
      .AUD_BCLK(clk), .rst_n(rst_n), .AUD_DACLRCK(lrck), .s_valid(s_valid),
      .s_ready(s_ready), .s_data(s_data), .AUD_DACDAT(dacdat),
      .fifo_level(fifo_level), .underflow(underflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // one BCLK: advance model at the edge, compare just after it, then move LRCK
   task automatic tick();
      logic is_edge, fall, rdy;
      int old_pos;
      @(posedge clk);
      old_pos = m_pos;
      is_edge = 1'b0;
      if (!rst_n) begin
         q.delete();
         m_cur = '0; m_word = '0; m_pos = N; m_uf = 1'b0;
      end else begin
         is_edge = lrck != m_prev;
         fall = is_edge && !lrck;
         rdy = q.size() < DEPTH;
         m_uf = fall && q.size() == 0;
         if (fall && q.size() > 0) m_cur = q.pop_front();
         if (s_valid && rdy) q.push_back(s_data);
         if (is_edge) begin
            m_word = m_cur; m_pos = 0;
         end else if (m_pos < N) m_pos++;
      end
      m_prev = lrck;
      #1;
      chk("dacdat", 32'(dacdat), 32'(m_pos < N ? m_word[N-1-m_pos] : 1'b0));
      chk("level", 32'(fifo_level), 32'(q.size()));
      chk("ready", 32'(s_ready), 32'(q.size() < DEPTH));
      chk("underflow", 32'(underflow), 32'(m_uf));
      if (is_edge) begin
         if (old_pos < N - 1) trunc = cap;
         cap = '0;
      end
      if (m_pos < N) begin
         cap[N-1-m_pos] = dacdat;
         if (m_pos == N - 1) sent.push_back(cap);
      end
      if (underflow === 1'b1) uf_cnt++;
      if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
      if (s_ready === 1'b0) low_ready++;
      lcnt++;
      if (lcnt == cur_len) begin
         lrck = ~lrck;
         lcnt = 0;
         cur_len = short_req ? 10 : 32;
         short_req = 1'b0;
      end
   endtask

   task automatic run_words(input int n);
      for (int i = 0; i < 70 * n + 70 && sent.size() < n; i++) tick();
      chk("words_avail", 32'(sent.size() >= n), 32'd1);
   endtask

   task automatic push(input logic [N-1:0] d);
      s_valid = 1'b1; s_data = d;
      tick();
      s_valid = 1'b0;
   endtask

   task automatic wait_lrck_start(input logic lv);
      for (int i = 0; i < 100 && !(lrck == lv && lcnt == 0); i++) tick();
   endtask

   initial begin
      repeat (4) tick();
      chk("rst_level", 32'(fifo_level), 32'd0);
      chk("rst_ready", 32'(s_ready), 32'd1);
      rst_n = 1'b1;
      push(16'hA5C3);
      chk("basic_level1", 32'(fifo_level), 32'd1);
      run_words(2);
      chk("basic_left", 32'(sent[0]), 32'h0000A5C3);
      chk("basic_right", 32'(sent[1]), 32'h0000A5C3);

      sent.delete(); uf_cnt = 0;
      push(16'h8001);
      run_words(8);
      for (int i = 0; i < 8; i++) chk("hold_word", 32'(sent[i]), 32'h00008001);
      chk("hold_uf_count", uf_cnt, 3);

      wait_lrck_start(1'b0);
      sent.delete();
      push(16'h1234);
      chk("same_cycle_uf", 32'(underflow), 32'd1);
      run_words(4);
      chk("same_prev_l", 32'(sent[0]), 32'h00008001);
      chk("same_prev_r", 32'(sent[1]), 32'h00008001);
      chk("same_new_l", 32'(sent[2]), 32'h00001234);
      chk("same_new_r", 32'(sent[3]), 32'h00001234);

      sent.delete(); max_level = 0; low_ready = 0;
      begin
         int cnt = 0;
         logic acc;
         s_valid = 1'b1;
         for (int i = 0; i < 640; i++) begin
            s_data = 16'(cnt);
            acc = s_ready;
            tick();
            if (acc) cnt++;
         end
         s_valid = 1'b0;
      end
      chk("bp_count", 32'(sent.size() >= 16), 32'd1);
      for (int i = 0; i < sent.size(); i++) chk("bp_seq", 32'(sent[i]), 32'(i / 2));
      chk("bp_max_level", max_level, DEPTH);
      chk("bp_ready_low", 32'(low_ready > 0), 32'd1);

      for (int i = 0; i < 600 && q.size() > 0; i++) tick();
      wait_lrck_start(1'b1);
      sent.delete();
      r1 = 16'($urandom); r2 = 16'($urandom);
      push(r1);
      push(r2);
      short_req = 1'b1;
      run_words(4);
      chk("short_right", 32'(sent[1]), 32'(r1));
      chk("short_next_l", 32'(sent[2]), 32'(r2));
      chk("short_next_r", 32'(sent[3]), 32'(r2));
      chk("short_trunc", 32'(trunc[N-1:N-9]), 32'(r1[N-1:N-9]));

      wait_lrck_start(1'b1);
      push(16'($urandom)); push(16'($urandom)); push(16'($urandom));
      for (int i = 0; i < 100 && !(m_pos == 7 && lrck == 1'b0); i++) tick();
      chk("rst_mid_pos", m_pos, 7);
      chk("rst_pre_level", 32'(fifo_level), 32'd2);
      rst_n = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();
      chk("rst_rel_dat", 32'(dacdat), 32'd0);
      chk("rst_rel_level", 32'(fifo_level), 32'd0);
      sent.delete(); uf_cnt = 0;
      run_words(4);
      for (int i = 0; i < 4; i++) chk("rst_zero_word", 32'(sent[i]), 32'd0);
      chk("rst_uf_count", uf_cnt, 2);
      r3 = 16'($urandom);
      push(r3);
      sent.delete();
      run_words(3);
      chk("rst_new_l", 32'(sent[1]), 32'(r3));
      chk("rst_new_r", 32'(sent[2]), 32'(r3));

      for (int i = 0; i < 1500; i++) begin
         s_valid = $urandom_range(0, 39) == 0;
         s_data = 16'($urandom);
         if ($urandom_range(0, 199) == 0) short_req = 1'b1;
         tick();
      end
      s_valid = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
